// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the pipeline stage registers
package pipe_pkg;

    typedef logic [4:0] exc_code_t;

    localparam exc_code_t EXC_NONE = 5'd0;
    localparam exc_code_t EXC_ADEL = 5'd4;
    localparam exc_code_t EXC_ADES = 5'd5;
    localparam exc_code_t EXC_OV   = 5'd12;

    localparam int W_IR = 0;
    localparam int W_PC = 1;
    localparam int F_BD = 0;

    localparam logic [31:0] NOP = 32'h0;

    // Oldest exception wins; a bubble never reports one.
    function automatic exc_code_t exc_pick(input logic valid, input exc_code_t older,
                                           input exc_code_t newer);
        exc_code_t res;
        res = EXC_NONE;
        if (valid) begin
            res = (older != EXC_NONE) ? older : newer;
        end
        return res;
    endfunction

endpackage

// File: rtl/pipe_stage_exc_merge.sv
// rtl/pipe_stage_exc_merge.sv - combinational priority merge of registered and local exception codes
module exc_merge
    import pipe_pkg::*;
(
    input  logic      valid,
    input  exc_code_t exc_reg,
    input  exc_code_t exc_local,
    output exc_code_t exc_out
);

    always_comb begin
        exc_out = exc_pick(valid, exc_reg, exc_local);
    end

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - inter-stage pipeline register with stall/flush/exception tracking (option: PIPE_STAGE_EXC_EN)
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int N_WORDS = 7,
    parameter int N_FLAGS = 4,
    parameter int CNT_W   = 8
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic [32*N_WORDS-1:0] words_in,
    input  logic [N_FLAGS-1:0]   flags_in,
    input  logic [4:0]           exc_in,
    input  logic [4:0]           exc_local,
    output logic [32*N_WORDS-1:0] words_out,
    output logic [N_FLAGS-1:0]   flags_out,
    output logic                 valid_out,
    output logic [4:0]           exc_out,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic               valid_d, valid_q;
    logic [N_FLAGS-1:0] flags_d, flags_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;

    // A flushed bubble still carries PC and BD so EPC is right if it becomes the victim.
    for (genvar k = 0; k < N_WORDS; k++) begin : g_word
        logic [31:0] word_d, word_q;

        always_comb begin
            word_d = word_q;
            if (flush) begin
                if (k == W_IR) begin
                    word_d = NOP;
                end else if (k == W_PC) begin
                    word_d = words_in[32*k +: 32];
                end
            end else if (en) begin
                word_d = words_in[32*k +: 32];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                word_q <= '0;
            end else begin
                word_q <= word_d;
            end
        end

        assign words_out[32*k +: 32] = word_q;
    end

    always_comb begin
        flags_d = flags_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            flags_d[F_BD] = flags_in[F_BD];
            valid_d       = 1'b0;
            cnt_d         = '0;
        end else if (en) begin
            flags_d = flags_in;
            valid_d = valid_in;
            cnt_d   = '0;
        end else if (valid_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_STAGE_EXC_EN
    exc_code_t exc_d, exc_q;

    always_comb begin
        exc_d = exc_q;
        if (flush) begin
            exc_d = EXC_NONE;
        end else if (en) begin
            exc_d = valid_in ? exc_in : EXC_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_q <= EXC_NONE;
        end else begin
            exc_q <= exc_d;
        end
    end

    exc_merge u_exc_merge (
        .valid     (valid_q),
        .exc_reg   (exc_q),
        .exc_local (exc_local),
        .exc_out   (exc_out)
    );
`else
    logic unused_exc;
    assign unused_exc = ^{exc_in, exc_local};

    // Tied-off merge: no register, output held at EXC_NONE.
    exc_merge u_exc_merge (
        .valid     (1'b0),
        .exc_reg   (EXC_NONE),
        .exc_local (EXC_NONE),
        .exc_out   (exc_out)
    );
`endif

    assign flags_out = flags_q;
    assign valid_out = valid_q;
    assign stall_cnt = cnt_q;

endmodule
